// File: rtl/snake_pkg.sv
// Shared definitions for the snake body engine.
//   dir_e    : direction encoding used by the key input and the movement logic
//   QH_*     : pixel query result codes returned to the VGA controller
//   state_e  : movement FSM states
//   is_reverse() : true when two directions point opposite ways
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    localparam logic [1:0] QH_EMPTY = 2'b00;
    localparam logic [1:0] QH_BODY  = 2'b01;
    localparam logic [1:0] QH_HEAD  = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StStep,
        StCheck,
        StDead
    } state_e;

    // Opposite directions share the axis bit [1] and differ in the sign bit [0].
    function automatic logic is_reverse(dir_e a, dir_e b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/snake_step_timer.sv
// Move-step timer: counts enabled cycles and wraps after STEP_DIV of them.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   en_i   : count enable (holds value when low)
//   clr_i  : synchronous clear to zero
//   tick_o : high in the enabled cycle where the count wraps
module snake_step_timer #(
    parameter int unsigned STEP_DIV = 12_500_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CntW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic [CntW-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == CntW'(STEP_DIV - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= tick_o ? '0 : cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/snake_body_engine.sv
// Snake body engine: segment register array on a GRID_W x GRID_H grid, advanced once per
// STEP_DIV run cycles, with direction filtering, growth, wall/self collision and a
// registered per-cell pixel query.
//   CLK_50M, RSTn             : clock, asynchronous active-low reset
//   run                       : enables movement
//   restart                   : re-initialise body and return to idle
//   dir_valid, dir            : direction request (reversals are dropped)
//   grow                      : lengthen by one at the next committed step
//   query_x, query_y          : cell to classify; query_hit answers one cycle later
//   head_x, head_y, length    : current head position and segment count
//   step_pulse                : one cycle after each committed move
//   hit_wall, hit_body, dead  : sticky death causes and dead state
module snake_body_engine
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W    = 40,
    parameter int unsigned GRID_H    = 30,
    parameter int unsigned X_W       = 6,
    parameter int unsigned Y_W       = 5,
    parameter int unsigned MAX_LEN   = 64,
    parameter int unsigned LEN_W     = 7,
    parameter int unsigned INIT_LEN  = 3,
    parameter int unsigned STEP_DIV  = 12_500_000,
    parameter int unsigned WRAP_MODE = 0
) (
    input  logic             CLK_50M,
    input  logic             RSTn,
    input  logic             run,
    input  logic             restart,
    input  logic             dir_valid,
    input  logic [1:0]       dir,
    input  logic             grow,
    input  logic [X_W-1:0]   query_x,
    input  logic [Y_W-1:0]   query_y,
    output logic [1:0]       query_hit,
    output logic [X_W-1:0]   head_x,
    output logic [Y_W-1:0]   head_y,
    output logic [LEN_W-1:0] length,
    output logic             step_pulse,
    output logic             hit_wall,
    output logic             hit_body,
    output logic             dead
);

    state_e           state_q;
    logic [X_W-1:0]   seg_x_q [MAX_LEN];
    logic [Y_W-1:0]   seg_y_q [MAX_LEN];
    logic [LEN_W-1:0] len_q;
    dir_e             cur_dir_q;
    dir_e             pend_dir_q;
    dir_e             step_dir_q;
    logic             grow_pend_q;
    logic [X_W-1:0]   nxt_x_q, nxt_x_d;
    logic [Y_W-1:0]   nxt_y_q, nxt_y_d;
    logic             nxt_wall_q, nxt_wall_d;
    logic             step_pulse_q;
    logic             hit_wall_q;
    logic             hit_body_q;
    logic             dead_q;
    logic [1:0]       query_hit_q;

    logic             step_tick;
    logic             grow_now;
    logic             body_hit;
    logic             q_head;
    logic             q_body;
    dir_e             dir_req;

    assign dir_req = dir_e'(dir);

    function automatic logic [X_W-1:0] init_x(int i);
        return (i < int'(INIT_LEN)) ? X_W'(int'(GRID_W / 2) - i) : '0;
    endfunction

    snake_step_timer #(
        .STEP_DIV(STEP_DIV)
    ) u_step_timer (
        .clk_i (CLK_50M),
        .rst_ni(RSTn),
        .en_i  ((state_q == StRun) && run),
        .clr_i (restart),
        .tick_o(step_tick)
    );

    // Candidate head one cell along the pending direction; edges either wrap or flag a wall.
    always_comb begin
        nxt_x_d    = seg_x_q[0];
        nxt_y_d    = seg_y_q[0];
        nxt_wall_d = 1'b0;
        unique case (pend_dir_q)
            DIR_UP: begin
                if (seg_y_q[0] == '0) begin
                    nxt_y_d    = Y_W'(GRID_H - 1);
                    nxt_wall_d = (WRAP_MODE == 0);
                end else begin
                    nxt_y_d = seg_y_q[0] - Y_W'(1);
                end
            end
            DIR_DOWN: begin
                if (seg_y_q[0] == Y_W'(GRID_H - 1)) begin
                    nxt_y_d    = '0;
                    nxt_wall_d = (WRAP_MODE == 0);
                end else begin
                    nxt_y_d = seg_y_q[0] + Y_W'(1);
                end
            end
            DIR_LEFT: begin
                if (seg_x_q[0] == '0) begin
                    nxt_x_d    = X_W'(GRID_W - 1);
                    nxt_wall_d = (WRAP_MODE == 0);
                end else begin
                    nxt_x_d = seg_x_q[0] - X_W'(1);
                end
            end
            DIR_RIGHT: begin
                if (seg_x_q[0] == X_W'(GRID_W - 1)) begin
                    nxt_x_d    = '0;
                    nxt_wall_d = (WRAP_MODE == 0);
                end else begin
                    nxt_x_d = seg_x_q[0] + X_W'(1);
                end
            end
            default: ;
        endcase
    end

    // The tail vacates its cell on a plain move, so it only counts as an obstacle when growing.
    always_comb begin
        grow_now = grow_pend_q && (len_q < LEN_W'(MAX_LEN));
        body_hit = 1'b0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (((i < int'(len_q) - 1) || (grow_now && (i == int'(len_q) - 1))) &&
                (seg_x_q[i] == nxt_x_q) && (seg_y_q[i] == nxt_y_q)) begin
                body_hit = 1'b1;
            end
        end
    end

    always_comb begin
        q_head = (query_x == seg_x_q[0]) && (query_y == seg_y_q[0]);
        q_body = 1'b0;
        for (int i = 1; i < int'(MAX_LEN); i++) begin
            if ((i < int'(len_q)) && (query_x == seg_x_q[i]) && (query_y == seg_y_q[i])) begin
                q_body = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            query_hit_q <= QH_EMPTY;
        end else if (q_head) begin
            query_hit_q <= QH_HEAD;
        end else if (q_body) begin
            query_hit_q <= QH_BODY;
        end else begin
            query_hit_q <= QH_EMPTY;
        end
    end

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= StIdle;
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= Y_W'(GRID_H / 2);
            end
            len_q        <= LEN_W'(INIT_LEN);
            cur_dir_q    <= DIR_RIGHT;
            pend_dir_q   <= DIR_RIGHT;
            step_dir_q   <= DIR_RIGHT;
            grow_pend_q  <= 1'b0;
            nxt_x_q      <= '0;
            nxt_y_q      <= '0;
            nxt_wall_q   <= 1'b0;
            step_pulse_q <= 1'b0;
            hit_wall_q   <= 1'b0;
            hit_body_q   <= 1'b0;
            dead_q       <= 1'b0;
        end else if (restart) begin
            state_q      <= StIdle;
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= Y_W'(GRID_H / 2);
            end
            len_q        <= LEN_W'(INIT_LEN);
            cur_dir_q    <= DIR_RIGHT;
            pend_dir_q   <= DIR_RIGHT;
            step_dir_q   <= DIR_RIGHT;
            grow_pend_q  <= 1'b0;
            nxt_wall_q   <= 1'b0;
            step_pulse_q <= 1'b0;
            hit_wall_q   <= 1'b0;
            hit_body_q   <= 1'b0;
            dead_q       <= 1'b0;
        end else begin
            step_pulse_q <= 1'b0;
            if (grow) begin
                grow_pend_q <= 1'b1;
            end
            // Reversal is judged against the committed heading, so a pending turn can still
            // be replaced by any non-reverse request before the step.
            if (dir_valid && (state_q != StDead) && !is_reverse(dir_req, cur_dir_q)) begin
                pend_dir_q <= dir_req;
            end
            unique case (state_q)
                StIdle: begin
                    if (run) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (!run) begin
                        state_q <= StIdle;
                    end else if (step_tick) begin
                        state_q <= StStep;
                    end
                end
                StStep: begin
                    nxt_x_q    <= nxt_x_d;
                    nxt_y_q    <= nxt_y_d;
                    nxt_wall_q <= nxt_wall_d;
                    step_dir_q <= pend_dir_q;
                    state_q    <= StCheck;
                end
                StCheck: begin
                    if (nxt_wall_q) begin
                        hit_wall_q <= 1'b1;
                        dead_q     <= 1'b1;
                        state_q    <= StDead;
                    end else if (body_hit) begin
                        hit_body_q <= 1'b1;
                        dead_q     <= 1'b1;
                        state_q    <= StDead;
                    end else begin
                        for (int i = 1; i < int'(MAX_LEN); i++) begin
                            seg_x_q[i] <= seg_x_q[i-1];
                            seg_y_q[i] <= seg_y_q[i-1];
                        end
                        seg_x_q[0]   <= nxt_x_q;
                        seg_y_q[0]   <= nxt_y_q;
                        if (grow_now) begin
                            len_q <= len_q + LEN_W'(1);
                        end
                        // A grow arriving in the commit cycle is kept for the next step.
                        grow_pend_q  <= grow;
                        cur_dir_q    <= step_dir_q;
                        step_pulse_q <= 1'b1;
                        state_q      <= StRun;
                    end
                end
                StDead: ;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign query_hit  = query_hit_q;
    assign head_x     = seg_x_q[0];
    assign head_y     = seg_y_q[0];
    assign length     = len_q;
    assign step_pulse = step_pulse_q;
    assign hit_wall   = hit_wall_q;
    assign hit_body   = hit_body_q;
    assign dead       = dead_q;

endmodule

// File: tb/tb_snake_body_engine.sv
module tb_snake_body_engine;

    localparam int GW = 40;
    localparam int GH = 30;
    localparam int XW = 6;
    localparam int YW = 5;
    localparam int ML = 64;
    localparam int LW = 7;
    localparam int IL = 3;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          restart = 1'b0;
    logic          dir_valid = 1'b0;
    logic [1:0]    dir = 2'b00;
    logic          grow = 1'b0;
    logic [XW-1:0] qx = '0;
    logic [YW-1:0] qy = '0;

    // Index 0: wall-kill instance, index 1: wrap-around instance; both share all inputs.
    logic [1:0]    qh [2];
    logic [XW-1:0] hx [2];
    logic [YW-1:0] hy [2];
    logic [LW-1:0] len [2];
    logic          sp [2];
    logic          hw [2];
    logic          hb [2];
    logic          dd [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_sp = 0;

    // Reference model: body as coordinate lists, head first.
    int bx [2][ML];
    int by [2][ML];
    int blen [2];
    int mcur [2];
    int mpend [2];
    bit mgp [2];
    bit mdead [2];
    bit mhw [2];
    bit mhb [2];
    bit mcommit [2];

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    snake_body_engine #(
        .GRID_W(GW), .GRID_H(GH), .X_W(XW), .Y_W(YW), .MAX_LEN(ML), .LEN_W(LW),
        .INIT_LEN(IL), .STEP_DIV(SD), .WRAP_MODE(0)
    ) dut_wall (
        .CLK_50M(clk), .RSTn(rst_n), .run(run), .restart(restart), .dir_valid(dir_valid),
        .dir(dir), .grow(grow), .query_x(qx), .query_y(qy), .query_hit(qh[0]),
        .head_x(hx[0]), .head_y(hy[0]), .length(len[0]), .step_pulse(sp[0]),
        .hit_wall(hw[0]), .hit_body(hb[0]), .dead(dd[0])
    );

    snake_body_engine #(
        .GRID_W(GW), .GRID_H(GH), .X_W(XW), .Y_W(YW), .MAX_LEN(ML), .LEN_W(LW),
        .INIT_LEN(IL), .STEP_DIV(SD), .WRAP_MODE(1)
    ) dut_wrap (
        .CLK_50M(clk), .RSTn(rst_n), .run(run), .restart(restart), .dir_valid(dir_valid),
        .dir(dir), .grow(grow), .query_x(qx), .query_y(qy), .query_hit(qh[1]),
        .head_x(hx[1]), .head_y(hy[1]), .length(len[1]), .step_pulse(sp[1]),
        .hit_wall(hw[1]), .hit_body(hb[1]), .dead(dd[1])
    );

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < ML; i++) begin
                bx[k][i] = (i < IL) ? GW / 2 - i : 0;
                by[k][i] = GH / 2;
            end
            blen[k] = IL; mcur[k] = 3; mpend[k] = 3;
            mgp[k] = 0; mdead[k] = 0; mhw[k] = 0; mhb[k] = 0; mcommit[k] = 0;
        end
    endtask

    function automatic bit opposite(int a, int b);
        return (a == 0 && b == 1) || (a == 1 && b == 0) || (a == 2 && b == 3) || (a == 3 && b == 2);
    endfunction

    task automatic m_step();
        int nx, ny, lim;
        bit g, hit;
        for (int k = 0; k < 2; k++) begin
            mcommit[k] = 0;
            if (mdead[k]) continue;
            nx = bx[k][0]; ny = by[k][0];
            case (mpend[k])
                0: ny = ny - 1;
                1: ny = ny + 1;
                2: nx = nx - 1;
                default: nx = nx + 1;
            endcase
            if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
                if (k == 0) begin
                    mdead[k] = 1; mhw[k] = 1;
                    continue;
                end
                nx = (nx + GW) % GW;
                ny = (ny + GH) % GH;
            end
            g = mgp[k] && (blen[k] < ML);
            lim = g ? blen[k] : blen[k] - 1;
            hit = 0;
            for (int i = 0; i < lim; i++) if (bx[k][i] == nx && by[k][i] == ny) hit = 1;
            if (hit) begin
                mdead[k] = 1; mhb[k] = 1;
                continue;
            end
            if (g) blen[k]++;
            for (int i = blen[k] - 1; i > 0; i--) begin
                bx[k][i] = bx[k][i-1]; by[k][i] = by[k][i-1];
            end
            bx[k][0] = nx; by[k][0] = ny;
            mgp[k] = 0; mcur[k] = mpend[k]; mcommit[k] = 1;
        end
    endtask

    function automatic int exp_q(int k, int x, int y);
        if (bx[k][0] == x && by[k][0] == y) return 2;
        for (int i = 1; i < blen[k]; i++) if (bx[k][i] == x && by[k][i] == y) return 1;
        return 0;
    endfunction

    // Drive a one-cycle input strobe starting at a falling edge, and mirror it into the model.
    task automatic pulse(input bit dv, input int d, input bit g, input bit rs);
        dir_valid = dv; dir = 2'(d); grow = g; restart = rs;
        @(negedge clk);
        dir_valid = 0; grow = 0; restart = 0;
        if (rs) m_reset();
        else begin
            for (int k = 0; k < 2; k++) begin
                if (dv && !mdead[k] && !opposite(d, mcur[k])) mpend[k] = d;
                if (g) mgp[k] = 1;
            end
        end
    endtask

    task automatic wait_first();
        bit got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (sp[0] || sp[1]) got = 1;
        end
        checks++;
        if (!got) begin
            $display("FAIL first_step: step_pulse seen=0, required 1 within 30 cycles");
            errors++;
        end
        m_step();
        last_sp = cyc;
    endtask

    // Steady-state steps are exactly STEP_DIV+2 cycles apart.
    task automatic advance();
        while (cyc < last_sp + SD + 2) @(negedge clk);
        m_step();
        last_sp = cyc;
    endtask

    task automatic test_reset();
        rst_n = 0; run = 0; qx = '0; qy = '0;
        m_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (hx[k] !== 6'd20 || hy[k] !== 5'd15) begin
                $display("FAIL reset_head k=%0d: got (%0d,%0d), expected (20,15)", k, hx[k], hy[k]);
                errors++;
            end
            checks++; if (len[k] !== 7'd3) begin
                $display("FAIL reset_len k=%0d: got %0d, expected 3", k, len[k]); errors++;
            end
            checks++; if ({sp[k], hw[k], hb[k], dd[k], qh[k]} !== 6'b0) begin
                $display("FAIL reset_flags k=%0d: got %b, expected 000000", k,
                         {sp[k], hw[k], hb[k], dd[k], qh[k]});
                errors++;
            end
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_query();
        int tx [6] = '{20, 19, 18, 17, 0, 21};
        int ty [6] = '{15, 15, 15, 15, 0, 15};
        int te [6] = '{2, 1, 1, 0, 0, 0};
        int rx, ry;
        qx = 6'd20; qy = 5'd15;
        #1;
        checks++; if (qh[0] !== 2'b00) begin
            $display("FAIL query_latency: got %0d before the clock edge, expected 0", qh[0]);
            errors++;
        end
        for (int j = 0; j < 6; j++) begin
            qx = XW'(tx[j]); qy = YW'(ty[j]);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++; if (int'(qh[k]) !== te[j]) begin
                    $display("FAIL query_fixed k=%0d (%0d,%0d): got %0d, expected %0d",
                             k, tx[j], ty[j], qh[k], te[j]);
                    errors++;
                end
            end
        end
        for (int j = 0; j < 6; j++) begin
            rx = (j % 2 == 0) ? $urandom_range(16, 22) : $urandom_range(0, GW - 1);
            ry = (j % 2 == 0) ? 15 : $urandom_range(0, GH - 1);
            qx = XW'(rx); qy = YW'(ry);
            @(negedge clk);
            checks++; if (int'(qh[1]) !== exp_q(1, rx, ry)) begin
                $display("FAIL query_rand (%0d,%0d): got %0d, expected %0d",
                         rx, ry, qh[1], exp_q(1, rx, ry));
                errors++;
            end
        end
    endtask

    task automatic test_basic();
        int tx [4] = '{21, 20, 19, 18};
        int te [4] = '{2, 1, 1, 0};
        run = 1;
        wait_first();
        for (int k = 0; k < 2; k++) begin
            checks++; if (hx[k] !== 6'd21 || hy[k] !== 5'd15 || len[k] !== 7'd3) begin
                $display("FAIL first_move k=%0d: got (%0d,%0d) len %0d, expected (21,15) len 3",
                         k, hx[k], hy[k], len[k]);
                errors++;
            end
        end
        // (18,15) was the tail before the move and must no longer be reported.
        for (int j = 0; j < 4; j++) begin
            qx = XW'(tx[j]); qy = 5'd15;
            @(negedge clk);
            checks++; if (int'(qh[0]) !== te[j]) begin
                $display("FAIL body_after_move (%0d,15): got %0d, expected %0d", tx[j], qh[0], te[j]);
                errors++;
            end
        end
        advance();
        checks++; if (sp[0] !== 1'b1 || sp[1] !== 1'b1 || hx[0] !== 6'd22) begin
            $display("FAIL step_latency: step_pulse %b%b head_x %0d, expected 11 and 22",
                     sp[0], sp[1], hx[0]);
            errors++;
        end
    endtask

    task automatic test_reverse();
        pulse(1, 2, 0, 0);
        advance();
        checks++; if (hx[0] !== 6'd23 || hy[0] !== 5'd15) begin
            $display("FAIL reverse_dropped: got (%0d,%0d), expected (23,15)", hx[0], hy[0]);
            errors++;
        end
        pulse(1, 0, 0, 0);
        advance();
        checks++; if (hx[1] !== 6'd23 || hy[1] !== 5'd14) begin
            $display("FAIL turn_up: got (%0d,%0d), expected (23,14)", hx[1], hy[1]);
            errors++;
        end
    endtask

    task automatic test_grow();
        int tail_x, tail_y;
        tail_x = bx[0][blen[0] - 1]; tail_y = by[0][blen[0] - 1];
        pulse(0, 0, 1, 0);
        pulse(0, 0, 1, 0);
        advance();
        for (int k = 0; k < 2; k++) begin
            checks++; if (len[k] !== 7'd4 || int'(len[k]) !== blen[k]) begin
                $display("FAIL grow_once k=%0d: got len %0d, expected 4", k, len[k]); errors++;
            end
        end
        qx = XW'(tail_x); qy = YW'(tail_y);
        @(negedge clk);
        checks++; if (qh[0] !== 2'b01) begin
            $display("FAIL grow_tail_kept (%0d,%0d): got %0d, expected 1", tail_x, tail_y, qh[0]);
            errors++;
        end
    endtask

    task automatic test_wall();
        int guard = 0;
        pulse(0, 0, 0, 1);
        wait_first();
        while (bx[0][0] < GW - 1 && guard < 40) begin
            advance();
            guard++;
        end
        checks++; if (hx[0] !== 6'd39 || dd[0] !== 1'b0) begin
            $display("FAIL wall_approach: got x %0d dead %b, expected 39 and 0", hx[0], dd[0]);
            errors++;
        end
        advance();
        checks++; if ({dd[0], hw[0], hb[0], sp[0]} !== 4'b1100 || hx[0] !== 6'd39) begin
            $display("FAIL wall_kill: got dead/wall/body/step %b x %0d, expected 1100 x 39",
                     {dd[0], hw[0], hb[0], sp[0]}, hx[0]);
            errors++;
        end
        checks++; if ({dd[1], hw[1], sp[1]} !== 3'b001 || hx[1] !== 6'd0 || hy[1] !== 5'd15) begin
            $display("FAIL wrap_move: got dead/wall/step %b head (%0d,%0d), expected 001 (0,15)",
                     {dd[1], hw[1], sp[1]}, hx[1], hy[1]);
            errors++;
        end
        advance();
        qx = 6'd39; qy = 5'd15;
        @(negedge clk);
        checks++; if (hx[0] !== 6'd39 || dd[0] !== 1'b1 || qh[0] !== 2'b10) begin
            $display("FAIL dead_hold: got x %0d dead %b query %0d, expected 39 1 2",
                     hx[0], dd[0], qh[0]);
            errors++;
        end
    endtask

    task automatic test_body();
        pulse(0, 0, 0, 1);
        wait_first();
        pulse(0, 0, 1, 0); advance();
        pulse(0, 0, 1, 0); advance();
        pulse(1, 0, 0, 0); advance();
        pulse(1, 2, 0, 0); advance();
        pulse(1, 1, 0, 0); advance();
        for (int k = 0; k < 2; k++) begin
            checks++; if ({dd[k], hb[k], hw[k], sp[k]} !== 4'b1100) begin
                $display("FAIL body_kill k=%0d: got dead/body/wall/step %b, expected 1100",
                         k, {dd[k], hb[k], hw[k], sp[k]});
                errors++;
            end
            checks++; if (hx[k] !== 6'd22 || hy[k] !== 5'd14 || len[k] !== 7'd5) begin
                $display("FAIL body_unchanged k=%0d: got (%0d,%0d) len %0d, expected (22,14) len 5",
                         k, hx[k], hy[k], len[k]);
                errors++;
            end
        end
        run = 0;
        pulse(0, 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            checks++; if (hx[k] !== 6'd20 || hy[k] !== 5'd15 || len[k] !== 7'd3 ||
                          {hw[k], hb[k], dd[k]} !== 3'b000) begin
                $display("FAIL restart k=%0d: got (%0d,%0d) len %0d flags %b, expected (20,15) 3 000",
                         k, hx[k], hy[k], len[k], {hw[k], hb[k], dd[k]});
                errors++;
            end
        end
        begin
            int seen = 0;
            repeat (12) begin
                @(negedge clk);
                if (sp[0] || sp[1] || hx[0] != 6'd20) seen++;
            end
            checks++; if (seen != 0) begin
                $display("FAIL idle_after_restart: got %0d moving cycles, expected 0", seen);
                errors++;
            end
        end
    endtask

    task automatic test_random();
        int rx, ry, d;
        bit dv, g;
        run = 1;
        for (int ep = 0; ep < 3; ep++) begin
            pulse(0, 0, 0, 1);
            wait_first();
            for (int s = 0; s < 40; s++) begin
                if (mdead[0] && mdead[1]) break;
                dv = ($urandom_range(0, 1) == 1);
                d = $urandom_range(0, 3);
                g = ($urandom_range(0, 4) == 0);
                pulse(dv, d, g, 0);
                if ($urandom_range(0, 1) == 1 && !mdead[1]) begin
                    int idx = $urandom_range(0, blen[1] - 1);
                    rx = bx[1][idx]; ry = by[1][idx];
                end else begin
                    rx = $urandom_range(0, GW - 1); ry = $urandom_range(0, GH - 1);
                end
                qx = XW'(rx); qy = YW'(ry);
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    checks++; if (int'(qh[k]) !== exp_q(k, rx, ry)) begin
                        $display("FAIL rand_query k=%0d (%0d,%0d): got %0d, expected %0d",
                                 k, rx, ry, qh[k], exp_q(k, rx, ry));
                        errors++;
                    end
                end
                advance();
                for (int k = 0; k < 2; k++) begin
                    checks++; if (sp[k] !== mcommit[k] || int'(hx[k]) !== bx[k][0] ||
                                  int'(hy[k]) !== by[k][0] || int'(len[k]) !== blen[k]) begin
                        $display("FAIL rand_step k=%0d: got step %b (%0d,%0d) len %0d, expected %b (%0d,%0d) len %0d",
                                 k, sp[k], hx[k], hy[k], len[k], mcommit[k], bx[k][0], by[k][0], blen[k]);
                        errors++;
                    end
                    checks++; if (dd[k] !== mdead[k] || hw[k] !== mhw[k] || hb[k] !== mhb[k]) begin
                        $display("FAIL rand_flags k=%0d: got dead/wall/body %b%b%b, expected %b%b%b",
                                 k, dd[k], hw[k], hb[k], mdead[k], mhw[k], mhb[k]);
                        errors++;
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        pulse(0, 0, 0, 1);
        wait_first();
        pulse(0, 0, 1, 0);
        advance();
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (hx[k] !== 6'd20 || hy[k] !== 5'd15 || len[k] !== 7'd3 ||
                          {sp[k], hw[k], hb[k], dd[k], qh[k]} !== 6'b0) begin
                $display("FAIL async_reset k=%0d: got (%0d,%0d) len %0d flags %b, expected (20,15) 3 000000",
                         k, hx[k], hy[k], len[k], {sp[k], hw[k], hb[k], dd[k], qh[k]});
                errors++;
            end
        end
        m_reset();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at 2 ms, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_query();
        test_basic();
        test_reverse();
        test_grow();
        test_wall();
        test_body();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
